// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared defaults, state encoding and helpers for the TDC measurement controller
package tdc_pkg;

  localparam int TDC_TOF_W_DEF   = 13;
  localparam int TDC_SHOT_W_DEF  = 4;
  localparam int TDC_TMO_W_DEF   = 12;
  localparam int TDC_GAP_CYC_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FIRE = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } tdc_state_e;

  function automatic int tdc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tdc_shot_acc.sv
// rtl/tdc_shot_acc.sv - per-measurement sum/min/hit-count accumulator
module tdc_shot_acc
  import tdc_pkg::*;
#(
  parameter int TOF_W  = TDC_TOF_W_DEF,
  parameter int SHOT_W = TDC_SHOT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    hit_en_i,
  input  logic [TOF_W-1:0]        tof_i,
  output logic [TOF_W+SHOT_W-1:0] sum_o,
  output logic [TOF_W-1:0]        min_o,
  output logic [SHOT_W-1:0]       hits_o
);

  localparam int SUM_W = TOF_W + SHOT_W;

  logic [SUM_W-1:0]  sum_q,  sum_d;
  logic [TOF_W-1:0]  min_q,  min_d;
  logic [SHOT_W-1:0] hits_q, hits_d;

  // Next accumulator value: clear wins over a hit; min starts at all-ones so the first hit always replaces it
  always_comb begin
    sum_d  = sum_q;
    min_d  = min_q;
    hits_d = hits_q;
    if (clr_i) begin
      sum_d  = '0;
      min_d  = '1;
      hits_d = '0;
    end else if (hit_en_i) begin
      sum_d  = sum_q + SUM_W'(tof_i);
      if (tof_i < min_q) begin
        min_d = tof_i;
      end
      hits_d = hits_q + SHOT_W'(1);
    end
  end

  // Accumulator registers, reset to the "no hits yet" values
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      min_q  <= '1;
      hits_q <= '0;
    end else begin
      sum_q  <= sum_d;
      min_q  <= min_d;
      hits_q <= hits_d;
    end
  end

  assign sum_o  = sum_q;
  assign min_o  = min_q;
  assign hits_o = hits_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// rtl/tdc_meas_ctrl.sv - burst-of-shots TDC measurement controller with result handshake
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int TOF_W   = TDC_TOF_W_DEF,
  parameter int SHOT_W  = TDC_SHOT_W_DEF,
  parameter int TMO_W   = TDC_TMO_W_DEF,
  parameter int GAP_CYC = TDC_GAP_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    meas_req,
  output logic                    busy,
  input  logic [SHOT_W-1:0]       cfg_shots,
  input  logic [7:0]              cfg_start_len,
  input  logic [TMO_W-1:0]        cfg_timeout,
  output logic                    tdc_start,
  input  logic                    tdc_valid,
  input  logic [TOF_W-1:0]        tdc_tof,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [TOF_W+SHOT_W-1:0] res_sum,
  output logic [TOF_W-1:0]        res_min,
  output logic [SHOT_W-1:0]       res_hits
);

  // One shared phase counter covers start width, timeout and gap, so it must fit the widest of them
  localparam int CNT_W = tdc_max(TMO_W, 8);

  tdc_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SHOT_W-1:0] shot_cnt_q;
  logic [SHOT_W-1:0] shots_q;
  logic [7:0]        start_len_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              shot_hit_q;
  logic              tdc_start_q;
  logic              busy_q;
  logic              res_valid_q;

  logic acc_clr;
  logic hit_en;
  logic fire_last;
  logic wait_last;
  logic gap_last;
  logic shot_last;

  assign acc_clr   = (state_q == ST_IDLE) && meas_req;
  // Only the first result of a shot counts, and only while the shot is live
  assign hit_en    = tdc_valid && !shot_hit_q && ((state_q == ST_FIRE) || (state_q == ST_WAIT));
  assign fire_last = (cnt_q == CNT_W'(start_len_q) - CNT_W'(1));
  assign wait_last = (cnt_q == CNT_W'(tmo_q) - CNT_W'(1));
  assign gap_last  = (cnt_q == CNT_W'(GAP_CYC - 1));
  assign shot_last = (shot_cnt_q == shots_q - SHOT_W'(1));

  // Measurement sequencer: fire / wait / gap per shot, then hold the result until it is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shot_cnt_q  <= '0;
      shots_q     <= SHOT_W'(1);
      start_len_q <= 8'd1;
      tmo_q       <= TMO_W'(1);
      shot_hit_q  <= 1'b0;
      tdc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (meas_req) begin
            shots_q     <= (cfg_shots == '0) ? SHOT_W'(1) : cfg_shots;
            start_len_q <= (cfg_start_len == '0) ? 8'd1 : cfg_start_len;
            tmo_q       <= (cfg_timeout == '0) ? TMO_W'(1) : cfg_timeout;
            cnt_q       <= '0;
            shot_cnt_q  <= '0;
            shot_hit_q  <= 1'b0;
            tdc_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          if (hit_en) begin
            shot_hit_q <= 1'b1;
          end
          if (fire_last) begin
            cnt_q       <= '0;
            tdc_start_q <= 1'b0;
            // A result that already arrived during the strobe makes the wait phase pointless
            state_q     <= (shot_hit_q || hit_en) ? ST_GAP : ST_WAIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (hit_en || wait_last) begin
            cnt_q      <= '0;
            shot_hit_q <= shot_hit_q | hit_en;
            state_q    <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_last) begin
            cnt_q      <= '0;
            shot_cnt_q <= shot_cnt_q + SHOT_W'(1);
            if (shot_last) begin
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              shot_hit_q  <= 1'b0;
              tdc_start_q <= 1'b1;
              state_q     <= ST_FIRE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  tdc_shot_acc #(
    .TOF_W  (TOF_W),
    .SHOT_W (SHOT_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (acc_clr),
    .hit_en_i (hit_en),
    .tof_i    (tdc_tof),
    .sum_o    (res_sum),
    .min_o    (res_min),
    .hits_o   (res_hits)
  );

  assign busy      = busy_q;
  assign tdc_start = tdc_start_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb/tb_tdc_meas_ctrl.sv - self-checking bench for the TDC measurement controller
module tb_tdc_meas_ctrl;

  localparam int TOF_W   = 13;
  localparam int SHOT_W  = 4;
  localparam int TMO_W   = 12;
  localparam int GAP_CYC = 4;
  localparam int SUM_W   = TOF_W + SHOT_W;
  localparam int MIN_NONE = (1 << TOF_W) - 1;

  localparam int M_NONE = 0;
  localparam int M_FIRE = 1;
  localparam int M_WAIT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              meas_req = 1'b0;
  logic              busy;
  logic [SHOT_W-1:0] cfg_shots = '0;
  logic [7:0]        cfg_start_len = '0;
  logic [TMO_W-1:0]  cfg_timeout = '0;
  logic              tdc_start;
  logic              tdc_valid = 1'b0;
  logic [TOF_W-1:0]  tdc_tof = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [SUM_W-1:0]  res_sum;
  logic [TOF_W-1:0]  res_min;
  logic [SHOT_W-1:0] res_hits;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int p_mode [16];
  int p_k    [16];
  int p_tof  [16];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  tdc_meas_ctrl #(
    .TOF_W   (TOF_W),
    .SHOT_W  (SHOT_W),
    .TMO_W   (TMO_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .meas_req      (meas_req),
    .busy          (busy),
    .cfg_shots     (cfg_shots),
    .cfg_start_len (cfg_start_len),
    .cfg_timeout   (cfg_timeout),
    .tdc_start     (tdc_start),
    .tdc_valid     (tdc_valid),
    .tdc_tof       (tdc_tof),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_sum       (res_sum),
    .res_min       (res_min),
    .res_hits      (res_hits)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles tdc_start stays low after a shot's strobe before the gap starts
  function automatic int wlen(input int mode, input int k, input int etmo);
    if (mode == M_FIRE) return 0;
    if (mode == M_WAIT) return k + 1;
    return etmo;
  endfunction

  task automatic set_plan(input int s, input int m, input int k, input int t);
    p_mode[s] = m;
    p_k[s]    = k;
    p_tof[s]  = t;
  endtask

  task automatic scramble_cfg();
    cfg_shots     = SHOT_W'($urandom);
    cfg_start_len = 8'($urandom);
    cfg_timeout   = TMO_W'($urandom);
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    meas_req  = 1'b0;
    tdc_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full measurement, starting and ending at a falling edge with the DUT idle
  task automatic do_meas(input int shots, input int sl, input int tmo, input bit junk,
                         input bit extra_req, input bit keep_req, input bit pre_ready,
                         input int hold);
    int es, esl, etmo, exp_sum, exp_min, exp_hits, exp_lat, wl, w, L, t0, n;
    es   = (shots == 0) ? 1 : shots;
    esl  = (sl == 0) ? 1 : sl;
    etmo = (tmo == 0) ? 1 : tmo;
    exp_sum  = 0;
    exp_min  = MIN_NONE;
    exp_hits = 0;
    exp_lat  = 1;
    for (int s = 0; s < es; s++) begin
      if (p_mode[s] != M_NONE) begin
        exp_sum += p_tof[s];
        if (p_tof[s] < exp_min) exp_min = p_tof[s];
        exp_hits++;
      end
      exp_lat += esl + wlen(p_mode[s], p_k[s], etmo) + GAP_CYC;
    end

    cfg_shots     = SHOT_W'(shots);
    cfg_start_len = 8'(sl);
    cfg_timeout   = TMO_W'(tmo);
    meas_req      = 1'b1;
    res_ready     = pre_ready;
    tdc_valid     = 1'b0;
    t0 = cyc;
    @(negedge clk);
    chk("accept_busy", busy, 1);
    chk("accept_start", tdc_start, 1);

    for (int s = 0; s < es; s++) begin
      w = 0;
      while (tdc_start === 1'b1 && w < 300) begin
        scramble_cfg();
        meas_req  = extra_req;
        tdc_valid = (p_mode[s] == M_FIRE && w == p_k[s]);
        tdc_tof   = tdc_valid ? TOF_W'(p_tof[s]) : TOF_W'($urandom);
        w++;
        @(negedge clk);
      end
      tdc_valid = 1'b0;
      chk("start_width", w, esl);
      chk("busy_in_burst", busy, 1);
      wl = wlen(p_mode[s], p_k[s], etmo);
      L = 0;
      while (tdc_start === 1'b0 && res_valid === 1'b0 && L < 5000) begin
        scramble_cfg();
        meas_req = extra_req;
        if (p_mode[s] == M_WAIT && L == p_k[s]) begin
          tdc_valid = 1'b1;
          tdc_tof   = TOF_W'(p_tof[s]);
        end else if (junk && L >= wl) begin
          tdc_valid = 1'b1;
          tdc_tof   = TOF_W'($urandom);
        end else begin
          tdc_valid = 1'b0;
        end
        L++;
        @(negedge clk);
      end
      tdc_valid = 1'b0;
      chk("low_len", L, wl + GAP_CYC);
      chk("shot_end_kind", res_valid, (s == es - 1) ? 1 : 0);
      if (res_valid === 1'b1) break;
    end

    n = 0;
    while (res_valid !== 1'b1 && n < 5000) begin
      tdc_valid = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("done_reached", res_valid, 1);
    if (res_valid !== 1'b1) begin
      reset_dut();
      return;
    end

    meas_req = keep_req;
    chk("latency", cyc - t0, exp_lat);
    chk("busy_done", busy, 1);
    chk("res_sum", res_sum, exp_sum);
    chk("res_min", res_min, exp_min);
    chk("res_hits", res_hits, exp_hits);

    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        scramble_cfg();
        tdc_valid = junk;
        tdc_tof   = TOF_W'($urandom);
        @(negedge clk);
        chk("hold_valid", res_valid, 1);
        chk("hold_sum", res_sum, exp_sum);
        chk("hold_min", res_min, exp_min);
        chk("hold_hits", res_hits, exp_hits);
      end
      tdc_valid = 1'b0;
      res_ready = 1'b1;
    end
    @(negedge clk);
    chk("hs_valid_drop", res_valid, 0);
    chk("hs_busy_drop", busy, 0);
    res_ready = 1'b0;
  endtask

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: observed no completion expected summary before time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sh, sl, tm, es, esl, etm, m;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_start", tdc_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_min", res_min, MIN_NONE);
    chk("rst_hits", res_hits, 0);
    rst = 1'b0;
    @(negedge clk);

    // single shot, hit well into the wait window
    set_plan(0, M_WAIT, 30, 400);
    do_meas(1, 20, 100, 0, 0, 0, 0, 1);

    // four shots, every result lands inside the strobe so the low time is exactly the gap
    set_plan(0, M_FIRE, $urandom_range(0, 19), 100);
    set_plan(1, M_FIRE, $urandom_range(0, 19), 90);
    set_plan(2, M_FIRE, $urandom_range(0, 19), 0);
    set_plan(3, M_FIRE, $urandom_range(0, 19), 120);
    do_meas(4, 20, 100, 1, 0, 0, 0, 2);

    // three silent shots run to timeout
    for (int s = 0; s < 3; s++) set_plan(s, M_NONE, 0, 0);
    do_meas(3, 5, 50, 0, 0, 0, 0, 0);

    // result on the exact timeout cycle plus a repeat, request held during the burst
    set_plan(0, M_WAIT, 9, 1234);
    set_plan(1, M_WAIT, 9, 77);
    do_meas(2, 3, 10, 1, 1, 0, 0, 1);

    // consumer stalls ten cycles
    set_plan(0, M_WAIT, 2, 5000);
    do_meas(1, 4, 8, 1, 0, 0, 0, 10);

    // minimum latency with ready already high
    set_plan(0, M_WAIT, 0, 8191);
    do_meas(1, 1, 1, 0, 0, 0, 1, 0);

    // zero configuration values behave as one
    set_plan(0, M_NONE, 0, 0);
    do_meas(0, 0, 0, 0, 0, 0, 0, 0);

    // request held through completion starts the next measurement back to back
    set_plan(0, M_FIRE, 0, 33);
    set_plan(1, M_NONE, 0, 0);
    do_meas(2, 2, 3, 0, 1, 1, 0, 1);
    set_plan(0, M_WAIT, 1, 44);
    do_meas(1, 2, 3, 0, 1, 0, 1, 0);

    // randomized bursts
    for (int r = 0; r < 10; r++) begin
      sh  = $urandom_range(0, 6);
      sl  = $urandom_range(0, 6);
      tm  = $urandom_range(0, 12);
      es  = (sh == 0) ? 1 : sh;
      esl = (sl == 0) ? 1 : sl;
      etm = (tm == 0) ? 1 : tm;
      for (int s = 0; s < 16; s++) begin
        m = $urandom_range(0, 2);
        if (m == M_FIRE) set_plan(s, m, $urandom_range(0, esl - 1), $urandom_range(0, MIN_NONE));
        else if (m == M_WAIT) set_plan(s, m, $urandom_range(0, etm - 1), $urandom_range(0, MIN_NONE));
        else set_plan(s, M_NONE, 0, 0);
      end
      do_meas(sh, sl, tm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // reset in the middle of the strobe after a hit was already taken
    cfg_shots     = 4'd2;
    cfg_start_len = 8'd8;
    cfg_timeout   = 12'd20;
    meas_req      = 1'b1;
    @(negedge clk);
    meas_req  = 1'b0;
    tdc_valid = 1'b1;
    tdc_tof   = 13'd777;
    @(negedge clk);
    tdc_valid = 1'b0;
    chk("pre_rst_start", tdc_start, 1);
    chk("pre_rst_sum", res_sum, 777);
    chk("pre_rst_hits", res_hits, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_start", tdc_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_sum", res_sum, 0);
    chk("mid_rst_min", res_min, MIN_NONE);
    chk("mid_rst_hits", res_hits, 0);
    rst       = 1'b0;
    tdc_valid = 1'b1;
    tdc_tof   = 13'd55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("late_valid_busy", busy, 0);
      chk("late_valid_hits", res_hits, 0);
    end
    tdc_valid = 1'b0;
    set_plan(0, M_WAIT, 3, 2222);
    set_plan(1, M_FIRE, 1, 11);
    do_meas(2, 3, 6, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
TDC_MEAS_CTRL -- requirements
Module: tdc_meas_ctrl

Interface
REQ-001 Parameter TOF_W, default 13, TDC time-of-flight result width.
REQ-002 Parameter SHOT_W, default 4, shot-count width; max shots per measurement 2^SHOT_W-1.
REQ-003 Parameter TMO_W, default 12, timeout counter width.
REQ-004 Parameter GAP_CYC, default 4, TDC re-arm gap in cycles between shots; legal range 1..255.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 meas_req  in  1  request to start one measurement (burst of shots).
REQ-008 busy  out  1  high from request acceptance until the result is accepted.
REQ-009 cfg_shots  in  SHOT_W  shots per measurement; 0 treated as 1.
REQ-010 cfg_start_len  in  8  tdc_start pulse width in cycles; 0 treated as 1.
REQ-011 cfg_timeout  in  TMO_W  cycles to wait for a TDC result after tdc_start falls; 0 treated as 1.
REQ-012 tdc_start  out  1  start strobe to TDC datapath.
REQ-013 tdc_valid  in  1  TDC result strobe, one cycle.
REQ-014 tdc_tof  in  TOF_W  TDC result, qualified by tdc_valid.
REQ-015 res_valid  out  1  result available; held until res_ready.
REQ-016 res_ready  in  1  result consumer ready.
REQ-017 res_sum  out  TOF_W+SHOT_W  sum of hit tof values.
REQ-018 res_min  out  TOF_W  minimum hit tof; all-ones if no hits.
REQ-019 res_hits  out  SHOT_W  number of shots that returned a result.

Function
REQ-020 FSM states IDLE, FIRE, WAIT, GAP, DONE; IDLE on reset.
REQ-021 IDLE: meas_req=1 -> latch cfg_shots/cfg_start_len/cfg_timeout, clear sum/min/hits/shot counter, go FIRE next cycle; busy=1 from that next cycle.
REQ-022 Latched cfg is used for the whole measurement; cfg input changes while busy have no effect.
REQ-023 FIRE: tdc_start=1 for exactly the latched start_len cycles (registered output), then WAIT.
REQ-024 WAIT: timeout counter counts from 0; tdc_valid=1 -> record hit, go GAP; counter reaching latched timeout-1 without tdc_valid -> go GAP, no hit.
REQ-025 tdc_valid in the same cycle as timeout expiry counts as a hit.
REQ-026 tdc_valid during FIRE records a hit and, after start_len completes, skips WAIT and goes to GAP.
REQ-027 Only the first tdc_valid per shot is recorded; tdc_valid in IDLE, GAP, DONE, or repeats within a shot are ignored.
REQ-028 Hit: sum += tdc_tof (zero-extended, no overflow possible at max parameters); min = min(min, tdc_tof); hits += 1; tof=0 is a valid hit.
REQ-029 GAP: tdc_start=0 for GAP_CYC cycles; shot counter +1; if shots done -> DONE else FIRE.
REQ-030 DONE: res_valid=1, res_* stable; res_ready=1 -> res_valid=0 and busy=0 next cycle, IDLE.
REQ-031 res_ready asserted before or in the first res_valid cycle completes the handshake in that cycle.
REQ-032 meas_req while busy is ignored (not queued); meas_req held high in IDLE after completion starts a new measurement.
REQ-033 Minimum measurement latency, 1 shot, start_len=1, immediate hit: meas_req accept -> res_valid in 1+1+1+GAP_CYC cycles.

Reset
REQ-034 rst=1 at any clock edge, including mid-FIRE, returns FSM to IDLE; next cycle: tdc_start=0, busy=0, res_valid=0, res_sum=0, res_min=all-ones, res_hits=0.
REQ-035 Pending TDC result arriving after reset is ignored (IDLE rule).

Structure
REQ-036 State encoding enum and default parameter values reside in shared package tdc_pkg.
REQ-037 One sub-module tdc_shot_acc (sum/min/hits accumulator with clear and hit-enable); FSM and counters stay in tdc_meas_ctrl.

Verification
REQ-038 shots=1, start_len=20, timeout=100, tdc_valid at 30 cycles after start fall with tof=400 -> res_sum=400, res_min=400, res_hits=1.
REQ-039 shots=4, tofs 100,90,0,120 -> res_sum=310, res_min=0, res_hits=4, tdc_start pulses=4, each 20 cycles wide, spaced by GAP_CYC.
REQ-040 shots=3, timeout=50, no tdc_valid -> three shots each 50 wait cycles, res_hits=0, res_sum=0, res_min=8191.
REQ-041 tdc_valid on exact timeout cycle plus second tdc_valid next cycle -> one hit counted; meas_req during burst ignored.
REQ-042 rst pulsed mid-FIRE -> tdc_start=0 and busy=0 next cycle; later tdc_valid ignored; fresh measurement succeeds.
REQ-043 res_ready held low 10 cycles in DONE -> res_* stable and res_valid high throughout; release -> single-cycle handshake.
